// File: rtl/alu_ops_pkg.sv
// Shared constants for the ALU-sharing arbiter: operation codes and FSM state encoding.
package alu_ops_pkg;

  // ALU operation select codes
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_NAND = 2'd2;
  localparam logic [1:0] ALU_NOR  = 2'd3;

  // Arbiter/sequencer FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alt_simple_unit.sv
// Purely combinational ALU: modulo add/sub and bitwise NAND/NOR.
module alt_simple_unit
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  // Operation decode; carry/borrow are intentionally dropped
  always_comb begin
    o_result = '0;
    case (i_sel)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_NAND: o_result = ~(i_a & i_b);
      ALU_NOR:  o_result = ~(i_a | i_b);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one alt_simple_unit between two
// valid/ready clients. Accept -> EXEC (one cycle) -> RESP (hold until the
// owning client takes the registered result).
module alu_share_arbiter
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [1:0]       req_sel_0,
  input  logic [1:0]       req_sel_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy,
  output logic             owner
);

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic             w_rsp_ready;
  logic [WIDTH-1:0] w_alu;

  assign w_idle = (r_state == ST_IDLE);

  // Grant: a lone requester wins; on contention the one not granted last wins
  always_comb begin
    w_grant = 1'b0;
    if (req_valid_0 && req_valid_1)
      w_grant = ~r_last_grant;
    else if (req_valid_1)
      w_grant = 1'b1;
  end

  assign w_accept    = w_idle & (req_valid_0 | req_valid_1);
  assign req_ready_0 = w_accept & ~w_grant;
  assign req_ready_1 = w_accept &  w_grant;

  // Only the owner's response handshake can release the RESP state
  assign w_rsp_ready = r_owner ? rsp_ready_1 : rsp_ready_0;

  assign rsp_valid_0 = (r_state == ST_RESP) & ~r_owner;
  assign rsp_valid_1 = (r_state == ST_RESP) &  r_owner;
  assign rsp_result  = r_result;
  assign busy        = ~w_idle;
  assign owner       = r_owner;

  alt_simple_unit #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_sel    (r_sel),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu)
  );

  // FSM, operand latch and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_sel        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel        <= w_grant ? req_sel_1 : req_sel_0;
            r_a          <= w_grant ? req_a_1   : req_a_0;
            r_b          <= w_grant ? req_b_1   : req_b_0;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_alu;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (WIDTH=8).
module tb_alu_share_arbiter;
  import alu_ops_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_0, req_valid_1;
  logic         req_ready_0, req_ready_1;
  logic [1:0]   req_sel_0, req_sel_1;
  logic [W-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic         rsp_valid_0, rsp_valid_1;
  logic         rsp_ready_0, rsp_ready_1;
  logic [W-1:0] rsp_result;
  logic         busy;
  logic         owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_sel_0   (req_sel_0),
    .req_sel_1   (req_sel_1),
    .req_a_0     (req_a_0),
    .req_a_1     (req_a_1),
    .req_b_0     (req_b_0),
    .req_b_1     (req_b_1),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_ready_0 (rsp_ready_0),
    .rsp_ready_1 (rsp_ready_1),
    .rsp_result  (rsp_result),
    .busy        (busy),
    .owner       (owner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy0"}, 32'(req_ready_0), 32'd0);
    chk({tag, "_rdy1"}, 32'(req_ready_1), 32'd0);
    chk({tag, "_vld0"}, 32'(rsp_valid_0), 32'd0);
    chk({tag, "_vld1"}, 32'(rsp_valid_1), 32'd0);
    chk({tag, "_busy"}, 32'(busy),        32'd0);
    chk({tag, "_res"},  32'(rsp_result),  32'd0);
    chk({tag, "_own"},  32'(owner),       32'd0);
  endtask

  // One operation from client k with its rsp_ready held high.
  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input int k, input logic [1:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    if (k == 0) begin
      req_valid_0 = 1'b1; req_sel_0 = sel; req_a_0 = a; req_b_0 = b; rsp_ready_0 = 1'b1;
    end else begin
      req_valid_1 = 1'b1; req_sel_1 = sel; req_a_1 = a; req_b_1 = b; rsp_ready_1 = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_rdy"},   32'(k == 0 ? req_ready_0 : req_ready_1), 32'd1);
    chk({tag, "_nrdy"},  32'(k == 0 ? req_ready_1 : req_ready_0), 32'd0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clk);
    chk({tag, "_exbusy"}, 32'(busy),  32'd1);
    chk({tag, "_owner"},  32'(owner), 32'(k));
    chk({tag, "_exvld"},  32'(rsp_valid_0 | rsp_valid_1), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"},  32'(k == 0 ? rsp_valid_0 : rsp_valid_1), 32'd1);
    chk({tag, "_nvld"}, 32'(k == 0 ? rsp_valid_1 : rsp_valid_0), 32'd0);
    chk({tag, "_res"},  32'(rsp_result), 32'(exp));
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_sel_0 = ALU_ADD; req_sel_1 = ALU_ADD;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;

    // Reset defaults
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_novalid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Contention: client 0 add 5+7, client 1 sub 3-5; expect 0,1,0,1 every 3 cycles
    req_valid_0 = 1'b1; req_sel_0 = ALU_ADD; req_a_0 = 8'd5; req_b_0 = 8'd7;
    req_valid_1 = 1'b1; req_sel_1 = ALU_SUB; req_a_1 = 8'd3; req_b_1 = 8'd5;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_rdy0", 32'(req_ready_0), 32'((i % 2) == 0));
      chk("cont_rdy1", 32'(req_ready_1), 32'((i % 2) == 1));
      @(negedge clk);
      chk("cont_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("cont_vld0", 32'(rsp_valid_0), 32'((i % 2) == 0));
      chk("cont_vld1", 32'(rsp_valid_1), 32'((i % 2) == 1));
      chk("cont_res",  32'(rsp_result),  (i % 2) == 0 ? 32'h0C : 32'hFE);
    end
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;

    // Single operations: add, wrap, logic ops; back-to-back single client
    run_op("add5p7",   0, ALU_ADD,  8'd5,  8'd7,  8'd12);
    run_op("sub3m5",   1, ALU_SUB,  8'd3,  8'd5,  8'hFE);
    run_op("addwrap",  1, ALU_ADD,  8'hFF, 8'h01, 8'h00);
    run_op("nand",     0, ALU_NAND, 8'hF0, 8'h3C, 8'hCF);
    run_op("nor",      0, ALU_NOR,  8'hF0, 8'h0F, 8'h00);
    run_op("nor2",     0, ALU_NOR,  8'hA0, 8'h05, 8'h5A);

    // Backpressure: client 1 stalls its response for 10 cycles, client 0 waits
    req_valid_1 = 1'b1; req_sel_1 = ALU_ADD; req_a_1 = 8'h10; req_b_1 = 8'h20;
    rsp_ready_1 = 1'b0; rsp_ready_0 = 1'b1;
    @(negedge clk);
    chk("bp_rdy1", 32'(req_ready_1), 32'd1);
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    req_valid_0 = 1'b1; req_sel_0 = ALU_ADD; req_a_0 = 8'd1; req_b_0 = 8'd1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_vld1", 32'(rsp_valid_1), 32'd1);
      chk("bp_vld0", 32'(rsp_valid_0), 32'd0);
      chk("bp_res",  32'(rsp_result),  32'h30);
      chk("bp_busy", 32'(busy),        32'd1);
      chk("bp_rdy0", 32'(req_ready_0), 32'd0);
    end
    rsp_ready_1 = 1'b1;
    #1;
    chk("bp_hs_rdy0", 32'(req_ready_0), 32'd0);
    @(posedge clk); #1;
    rsp_ready_1 = 1'b0;
    @(negedge clk);
    chk("bp_after_rdy0", 32'(req_ready_0), 32'd1);
    chk("bp_after_busy", 32'(busy),        32'd0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_c0_vld", 32'(rsp_valid_0), 32'd1);
    chk("bp_c0_res", 32'(rsp_result),  32'h02);
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0;

    // Reset during EXEC (client 1 owns, so owner must fall back to 0)
    req_valid_1 = 1'b1; req_sel_1 = ALU_ADD; req_a_1 = 8'h11; req_b_1 = 8'h22;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    @(negedge clk);
    chk("rexec_pre_own", 32'(owner), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during RESP
    req_valid_1 = 1'b1; req_sel_1 = ALU_SUB; req_a_1 = 8'h40; req_b_1 = 8'h01;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rresp_pre_vld", 32'(rsp_valid_1), 32'd1);
    chk("rresp_pre_res", 32'(rsp_result),  32'h3F);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal completion after reset
    run_op("post_rst", 1, ALU_NAND, 8'hFF, 8'h0F, 8'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
